fsrc_accum_multi: RTL
=====================

# fsrc_accum_multi

Multi-channel accumulator for the FSRC transmit datapath. Each of NUM_CH independent channels loads a value on `set` or adds an increment on `add`, wrapping or saturating against a programmable modulus. Every channel reports an overflow pulse, a sticky overflow flag and a saturating overflow count. Sits between the rate-control registers and the sample-strobe generation logic, one channel per converter lane.

## Interface
- `WIDTH`, 32: accumulator width per channel.
- `NUM_CH`, 4: number of independent channels.
- `CNT_WIDTH`, 8: width of the per-channel overflow counter.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `set_val`  in  NUM_CH*WIDTH  load values; channel c occupies bits [c*WIDTH +: WIDTH].
- `set`  in  NUM_CH  per-channel load strobe.
- `add_val`  in  NUM_CH*WIDTH  per-channel increment.
- `add`  in  NUM_CH  per-channel add strobe.
- `modulus`  in  WIDTH  shared wrap point; 0 means 2^WIDTH.
- `sat_en`  in  1  1 = saturate on overflow, 0 = wrap.
- `sticky_clr`  in  NUM_CH  per-channel clear of the sticky flag and the counter.
- `accum`  out  NUM_CH*WIDTH  accumulator values.
- `overflow`  out  NUM_CH  one-cycle overflow pulse.
- `overflow_sticky`  out  NUM_CH  latched overflow flag.
- `overflow_cnt`  out  NUM_CH*CNT_WIDTH  saturating overflow count.

## Operation
- Channels are fully independent. Only `modulus` and `sat_en` are shared.
- Each channel evaluates its inputs every cycle, in priority order: `set`, then `add`, then hold.
- **Set:** `accum` <= `set_val` and `overflow` <= 0. `set_val` is not range-checked against `modulus`.
- **Add:** compute sum = `accum` + `add_val` at WIDTH+1 bits. The limit L is 2^WIDTH if `modulus` = 0, otherwise `modulus`.
  - **Overflow condition:** sum >= L.
  - **Wrap mode (`sat_en` = 0), overflow:** `accum` <= sum - L, truncated to WIDTH. Exactly one subtraction is performed. If the inputs violate `accum` < L or `add_val` < L, the result is still sum - L truncated, with no further correction.
  - **Saturate mode (`sat_en` = 1), overflow:** `accum` <= L - 1.
  - **No overflow:** `accum` <= sum.
  - **`overflow`:** <= overflow condition.
- **Hold (neither `set` nor `add`):** `accum` is unchanged and `overflow` <= 0. `overflow` is therefore a single-cycle pulse per overflowing add, never a held level.
- **Sticky flag:** `overflow_sticky` is set by any overflowing add and cleared by `sticky_clr`. If both occur in the same cycle, the flag is 1 (set wins). `set` does not affect the sticky flag.
- **Counter:** `overflow_cnt` increments by 1 per overflowing add and saturates at 2^CNT_WIDTH - 1.
  - `sticky_clr` zeroes the counter.
  - `sticky_clr` together with an overflowing add gives a count of 1.
  - `set` does not affect the counter.
- **Mode changes:** `modulus` and `sat_en` changes take effect on the next add. Stored `accum` values are not re-normalised.

## Timing
- **Reset:** while `resetn` = 0, all `accum`, `overflow`, `overflow_sticky` and `overflow_cnt` are 0, asynchronously. Deassertion is synchronous to `clk` (upstream reset synchroniser).
- **Latency:** 1 cycle. An input sampled at edge N is visible on all outputs after edge N.
- **Throughput:** one add per channel per cycle. Back-to-back adds chain on the registered `accum`.
- **Reset mid-operation:** clears all state immediately. The first add after release starts from 0.
- **Simultaneous `set` and `add`:** `set` wins, the add is dropped, and no overflow is reported.
- No combinational path from inputs to outputs.

## Test plan
- **Reset and hold:** WIDTH=32, hold reset for 3 cycles -> all outputs 0. Release with no strobes for 10 cycles -> outputs stay 0.
- **2^WIDTH wrap:** `modulus`=0, set 0xFFFF_FFF0, then add 0x20 -> `accum`=0x10, `overflow` high for exactly one cycle, sticky=1, cnt=1. The next idle cycle has `overflow`=0.
- **Programmable modulus:** `modulus`=1000, `add_val`=300 from 0 for 4 adds -> `accum` 300, 600, 900, 200. `overflow` pulses only on the 4th add. Then `sat_en`=1 and add 900 -> `accum`=999, `overflow` pulse.
- **Priority and clear races:**
  - `set`=1, `add`=1, `set_val`=5 -> `accum`=5, no overflow.
  - `sticky_clr` on the same cycle as an overflowing add -> sticky=1, cnt=1.
- **Counter saturation:** CNT_WIDTH=8, 300 overflowing adds -> cnt=255. Then `sticky_clr` -> cnt=0, sticky=0.
- **Channel independence:** NUM_CH=4, overflow channel 2 only -> only bit 2 of `overflow`, sticky and cnt change. Assert async reset mid-stream -> all four channels are 0 before the next edge.

Source files
------------

// File: rtl/fsrc_accum_multi.sv
// Multi-channel load/add accumulator with programmable modulus, wrap or saturate,
// and per-channel overflow pulse, sticky flag and saturating overflow count.
module fsrc_accum_multi #(
  parameter int WIDTH     = 32,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_CH*WIDTH-1:0]     set_val,
  input  logic [NUM_CH-1:0]           set,
  input  logic [NUM_CH*WIDTH-1:0]     add_val,
  input  logic [NUM_CH-1:0]           add,
  input  logic [WIDTH-1:0]            modulus,
  input  logic                        sat_en,
  input  logic [NUM_CH-1:0]           sticky_clr,
  output logic [NUM_CH*WIDTH-1:0]     accum,
  output logic [NUM_CH-1:0]           overflow,
  output logic [NUM_CH-1:0]           overflow_sticky,
  output logic [NUM_CH*CNT_WIDTH-1:0] overflow_cnt
);

  localparam logic [WIDTH:0]     LIM_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]     LIM_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // A modulus of zero stands for the full 2^WIDTH range.
  logic [WIDTH:0] w_lim;
  assign w_lim = (modulus == '0) ? LIM_FULL : {1'b0, modulus};

  // Single subtraction only; out-of-range operands are deliberately not corrected.
  function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH:0] sum,
                                                input logic [WIDTH:0] lim);
    logic [WIDTH:0] diff;
    diff = sum - lim;
    return diff[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_top(input logic [WIDTH:0] lim);
    logic [WIDTH:0] top;
    top = lim - LIM_ONE;
    return top[WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0]     r_acc;
    logic                 r_ovf;
    logic                 r_sticky;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH:0]       w_sum;
    logic                 w_hit;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic                 w_sticky_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    assign w_sum = {1'b0, r_acc} + {1'b0, add_val[c*WIDTH +: WIDTH]};
    // A set in the same cycle swallows the add, including its overflow.
    assign w_hit = add[c] & ~set[c] & (w_sum >= w_lim);

    always_comb begin
      w_acc_nxt = r_acc;
      if (set[c]) begin
        w_acc_nxt = set_val[c*WIDTH +: WIDTH];
      end else if (add[c]) begin
        if (w_hit) w_acc_nxt = sat_en ? sat_top(w_lim) : wrap_sub(w_sum, w_lim);
        else       w_acc_nxt = w_sum[WIDTH-1:0];
      end
    end

    // An overflow in the clearing cycle wins: flag stays set and the count restarts at 1.
    always_comb begin
      w_sticky_nxt = r_sticky;
      w_cnt_nxt    = r_cnt;
      if (w_hit) begin
        w_sticky_nxt = 1'b1;
        w_cnt_nxt    = sticky_clr[c] ? CNT_ONE : cnt_inc(r_cnt);
      end else if (sticky_clr[c]) begin
        w_sticky_nxt = 1'b0;
        w_cnt_nxt    = '0;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_acc    <= '0;
        r_ovf    <= 1'b0;
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_acc    <= w_acc_nxt;
        r_ovf    <= w_hit;
        r_sticky <= w_sticky_nxt;
        r_cnt    <= w_cnt_nxt;
      end
    end

    assign accum[c*WIDTH +: WIDTH]            = r_acc;
    assign overflow[c]                        = r_ovf;
    assign overflow_sticky[c]                 = r_sticky;
    assign overflow_cnt[c*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

endmodule
